// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // MUL is treated as signed x signed; its low half is sign-agnostic anyway.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on magnitudes.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN:0]   i_acc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opd,
  output logic [XLEN:0]   o_acc,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_sh;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  always_comb begin
    // Multiply: {acc, lo} is the running product, multiplier bits retire from lo[0].
    w_sum  = i_acc + (i_lo[0] ? {1'b0, i_opd} : '0);
    // Divide: acc is the partial remainder, dividend bits enter from lo's MSB.
    w_sh   = {i_acc[XLEN-1:0], i_lo[XLEN-1]};
    w_diff = {1'b0, w_sh} - {2'b00, i_opd};
    w_ge   = ~w_diff[XLEN+1];
    if (i_div) begin
      o_acc = w_ge ? w_diff[XLEN:0] : w_sh;
      o_lo  = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_acc = {1'b0, w_sum[XLEN:1]};
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN steps) -> FIX (sign/select) -> DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FASTPATH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      MDcode,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] MDresult,
  output logic            busy
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_V    = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state, w_nxt;
  logic [2:0]      r_op;
  logic            r_sa, r_sb, r_dz, r_vld;
  logic [CW-1:0]   r_cnt;
  logic [XLEN:0]   r_acc;
  logic [XLEN-1:0] r_lo, r_opd, r_res;

  logic            w_accept, w_sa, w_sb, w_dz, w_ovf, w_fast;
  logic [XLEN-1:0] w_absa, w_absb, w_fast_res;
  logic [XLEN:0]   w_step_acc;
  logic [XLEN-1:0] w_step_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = ~in_ready;
  assign out_valid = r_vld;
  assign MDresult  = r_res;

  // Operand conditioning at accept time.
  always_comb begin
    w_accept   = in_valid & (r_state == ST_IDLE) & ~flush;
    w_sa       = is_signed_a(MDcode) & srcA[XLEN-1];
    w_sb       = is_signed_b(MDcode) & srcB[XLEN-1];
    w_absa     = w_sa ? -srcA : srcA;
    w_absb     = w_sb ? -srcB : srcB;
    w_dz       = is_div(MDcode) && (srcB == '0);
    w_ovf      = is_div(MDcode) && is_signed_b(MDcode) && (srcA == MIN_V) && (srcB == '1);
    w_fast     = FASTPATH && (w_dz || w_ovf);
    w_fast_res = is_rem(MDcode) ? (w_dz ? srcA : '0) : (w_dz ? '1 : srcA);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div (is_div(r_op)),
    .i_acc (r_acc),
    .i_lo  (r_lo),
    .i_opd (r_opd),
    .o_acc (w_step_acc),
    .o_lo  (w_step_lo)
  );

  // Sign fix and result select; divide-by-zero quotient is forced to all ones.
  always_comb begin
    w_prod     = {r_acc[XLEN-1:0], r_lo};
    w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    w_quo      = r_dz ? '1 : ((r_sa ^ r_sb) ? -r_lo : r_lo);
    w_rem      = r_sa ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_fix_res  = w_quo;
    if (!is_div(r_op))
      w_fix_res = (r_op == MD_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    else if (is_rem(r_op))
      w_fix_res = w_rem;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nxt = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CW'(1)) w_nxt = ST_FIX;
      ST_FIX:  w_nxt = ST_DONE;
      ST_DONE: if (r_vld && out_ready) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
    if (flush) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_lo    <= '0;
      r_opd   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_nxt;
      // out_valid rises one edge after DONE is entered and falls on handoff or flush.
      r_vld   <= ~flush & (r_state == ST_DONE) & ~(r_vld & out_ready);
      if (w_accept) begin
        r_op  <= MDcode;
        r_sa  <= w_sa;
        r_sb  <= w_sb;
        r_dz  <= w_dz;
        r_cnt <= CNT_INIT;
        r_acc <= '0;
        if (is_div(MDcode)) begin
          r_lo  <= w_absa;
          r_opd <= w_absb;
        end else begin
          r_lo  <= w_absb;
          r_opd <= w_absa;
        end
        if (w_fast) r_res <= w_fast_res;
      end else if (r_state == ST_CALC) begin
        r_acc <= w_step_acc;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == ST_FIX) begin
        r_res <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one FASTPATH=1 and one FASTPATH=0 instance, vectors, random ops, corner sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       in_valid_v, in_ready_v, flush_v, out_valid_v, out_ready_v, busy_v;
  logic [1:0][2:0]  mdcode_v;
  logic [1:0][31:0] srca_v, srcb_v, res_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FASTPATH(1'b1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .MDcode(mdcode_v[0]), .srcA(srca_v[0]), .srcB(srcb_v[0]), .flush(flush_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .MDresult(res_v[0]), .busy(busy_v[0]));

  muldiv_unit #(.XLEN(32), .FASTPATH(1'b0)) u_slow (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .MDcode(mdcode_v[1]), .srcA(srca_v[1]), .srcB(srcb_v[1]), .flush(flush_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .MDresult(res_v[1]), .busy(busy_v[1]));

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[$];

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = op[2] && ((b == 0) ||
           ((op == MD_DIV || op == MD_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return (d == 0 && fast) ? 1 : 34;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdcode_v[d] = op; srca_v[d] = a; srcb_v[d] = b; in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    mdcode_v[d] = 3'($urandom); srca_v[d] = $urandom; srcb_v[d] = $urandom;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (out_valid_v[d] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int d, input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int elat);
    int lat;
    out_ready_v[d] = 1'b1;
    start_op(d, op, a, b);
    wait_valid(d, lat);
    chk({nm, " result"}, res_v[d], exp);
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    @(posedge clk); #1;
    chk({nm, " in_ready after handoff"}, 32'(in_ready_v[d]), 32'd1);
  endtask

  logic [2:0]  rop;
  logic [31:0] ra, rb;
  int          rd, lat, sel;
  bit          seen;

  initial begin
    rst = 1'b1;
    in_valid_v = '0; flush_v = '0; out_ready_v = '0;
    mdcode_v = '0; srca_v = '0; srcb_v = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset in_ready d%0d", d), 32'(in_ready_v[d]), 32'd1);
      chk($sformatf("reset out_valid d%0d", d), 32'(out_valid_v[d]), 32'd0);
      chk($sformatf("reset busy d%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("reset MDresult d%0d", d), res_v[d], 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    vecs.push_back('{"MUL 7*-3",        MD_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"MULHU 7*fffffffd", MD_MULHU, 32'h7,        32'hFFFFFFFD, 32'h00000006, 1'b0});
    vecs.push_back('{"MULH min*min",    MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
    vecs.push_back('{"MULHSU -1*max",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"MUL min*-1",      MD_MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{"DIV -7/2",        MD_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"REM -7/2",        MD_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"DIVU 100/7",      MD_DIVU,   32'd100,      32'd7,        32'd14,       1'b0});
    vecs.push_back('{"REMU 100/7",      MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0});
    vecs.push_back('{"DIVU 5/0",        MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"REMU 5/0",        MD_REMU,   32'd5,        32'd0,        32'd5,        1'b1});
    vecs.push_back('{"DIV min/-1",      MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{"REM min/-1",      MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{"DIV -7/0",        MD_DIV,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"REM -7/0",        MD_REM,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b1});

    for (int d = 0; d < 2; d++)
      foreach (vecs[i])
        run_op(d, $sformatf("%s d%0d", vecs[i].name, d), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].exp, (d == 0 && vecs[i].fast) ? 1 : 34);

    for (int n = 0; n < 60; n++) begin
      rd  = $urandom_range(0, 1);
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel < 4) rb = $urandom_range(1, 15);
      else if (sel == 4) rb = -$urandom_range(1, 15);
      else rb = $urandom;
      run_op(rd, $sformatf("rand%0d op%0d %h,%h d%0d", n, rop, ra, rb, rd), rop, ra, rb,
             ref_md(rop, ra, rb), exp_lat(rd, rop, ra, rb));
    end

    // Backpressure in DONE, with a stray request that must be ignored.
    out_ready_v[0] = 1'b0;
    start_op(0, MD_MUL, 32'd3, 32'd5);
    wait_valid(0, lat);
    chk("bp latency", 32'(lat), 32'd34);
    @(negedge clk);
    in_valid_v[0] = 1'b1; mdcode_v[0] = MD_DIVU; srca_v[0] = 32'd9; srcb_v[0] = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp out_valid c%0d", i), 32'(out_valid_v[0]), 32'd1);
      chk($sformatf("bp result c%0d", i), res_v[0], 32'd15);
      chk($sformatf("bp in_ready c%0d", i), 32'(in_ready_v[0]), 32'd0);
    end
    @(negedge clk); in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp in_ready after release", 32'(in_ready_v[0]), 32'd1);
    chk("bp out_valid after release", 32'(out_valid_v[0]), 32'd0);

    // Flush mid-CALC: no result may ever appear.
    start_op(0, MD_MULHU, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(posedge clk);
    @(negedge clk); flush_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("flush busy", 32'(busy_v[0]), 32'd0);
    chk("flush in_ready", 32'(in_ready_v[0]), 32'd1);
    @(negedge clk); flush_v[0] = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid_v[0]) seen = 1'b1; end
    chk("flush no out_valid", 32'(seen), 32'd0);

    // Flush together with in_valid in IDLE: not accepted.
    @(negedge clk);
    flush_v[0] = 1'b1; in_valid_v[0] = 1'b1; mdcode_v[0] = MD_DIVU; srca_v[0] = 32'd50; srcb_v[0] = 32'd3;
    @(posedge clk); #1;
    chk("flush+in_valid busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk); flush_v[0] = 1'b0; in_valid_v[0] = 1'b0;

    // Flush while holding a finished result.
    out_ready_v[0] = 1'b0;
    start_op(0, MD_DIVU, 32'd5, 32'd0);
    wait_valid(0, lat);
    chk("flush-done latency", 32'(lat), 32'd1);
    @(negedge clk); flush_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("flush-done out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("flush-done in_ready", 32'(in_ready_v[0]), 32'd1);
    @(negedge clk); flush_v[0] = 1'b0;
    run_op(0, "after flush DIVU 50/3", MD_DIVU, 32'd50, 32'd3, 32'd16, 34);

    // Asynchronous reset mid-CALC.
    start_op(1, MD_DIV, 32'hFFFFFF00, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy_v[1]), 32'd0);
    chk("rst in_ready", 32'(in_ready_v[1]), 32'd1);
    chk("rst out_valid", 32'(out_valid_v[1]), 32'd0);
    chk("rst MDresult", res_v[1], 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(1, "after rst REM -256/3", MD_REM, 32'hFFFFFF00, 32'd3, 32'hFFFFFFFF, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
